// File: rtl/pc_gen_ctrl.sv
// pc_gen_ctrl: fetch PC generator with multiple outstanding fetch requests.
// Issues sequential fetches, tracks in-flight request addresses in a small
// FIFO, pairs returned instructions with their PC, and squashes stale
// responses after any redirect (trap > EX redirect > branch predictor).
// Optional performance counters are enabled by defining PCGEN_PERF_EN.
module pc_gen_ctrl #(
  parameter int               XLEN            = 32,
  parameter int               MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0]  BOOT_ADDR       = '0
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              fetch_en,
  input  logic              freeze,
  input  logic              trap_vld,
  input  logic [XLEN-1:0]   trap_pc,
  input  logic              ex_redir_vld,
  input  logic [XLEN-1:0]   ex_redir_pc,
  input  logic              bp_taken,
  input  logic [XLEN-1:0]   bp_pc,
  output logic              req_vld,
  output logic [XLEN-1:0]   req_addr,
  input  logic              req_rdy,
  input  logic              rsp_vld,
  input  logic [31:0]       rsp_data,
  output logic              rsp_rdy,
  output logic              if_vld,
  output logic [XLEN-1:0]   if_pc,
  output logic [XLEN-1:0]   if_pc_nxt,
  output logic [31:0]       if_instr,
  input  logic              if_rdy
`ifdef PCGEN_PERF_EN
  ,
  output logic [31:0]       perf_redir_cnt,
  output logic [31:0]       perf_drop_cnt
`endif
);

  // Pointer width is kept at least one bit so a single-entry FIFO still works.
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W:0]   MAX_INFL  = (CNT_W + 1)'(MAX_OUTSTANDING);
  localparam logic [XLEN-1:0]  PC_STEP   = XLEN'(4);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Registered state
  state_t                 state_q, state_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic [XLEN-1:0]        fifo_mem_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       fifo_cnt_q, fifo_cnt_d;
  logic [CNT_W-1:0]       kill_cnt_q, kill_cnt_d;

  // Combinational helpers
  logic                   redir;
  logic [XLEN-1:0]        redir_target;
  logic [CNT_W:0]         inflight;
  logic                   req_fire;
  logic                   rsp_fire;
  logic                   fifo_empty;
  logic                   kill_active;
  logic                   push;
  logic                   pop;
  logic                   drop;

  // Redirect detection, prioritised target selection and in-flight count.
  always_comb begin
    redir        = trap_vld | ex_redir_vld | bp_taken;
    redir_target = bp_pc;
    if (trap_vld) begin
      redir_target = trap_pc;
    end else if (ex_redir_vld) begin
      redir_target = ex_redir_pc;
    end
    redir_target = {redir_target[XLEN-1:2], 2'b00};
    inflight     = {1'b0, fifo_cnt_q} + {1'b0, kill_cnt_q};
    fifo_empty   = (fifo_cnt_q == '0);
    kill_active  = (kill_cnt_q != '0);
  end

  // Request side: issue a fetch whenever running, enabled and under the cap.
  always_comb begin
    req_vld  = (state_q == ST_RUN) & fetch_en & ~freeze & ~redir &
               (inflight < MAX_INFL);
    req_addr = pc_q;
    req_fire = req_vld & req_rdy;
  end

  // Response side: drop stale responses, otherwise hand them to IF.
  always_comb begin
    rsp_rdy   = kill_active | redir | if_rdy;
    rsp_fire  = rsp_vld & rsp_rdy;
    if_vld    = rsp_vld & ~kill_active & ~redir & ~fifo_empty;
    if_pc     = fifo_mem_q[rd_ptr_q];
    if_pc_nxt = fifo_mem_q[rd_ptr_q] + PC_STEP;
    if_instr  = rsp_data;
    drop      = rsp_fire & (kill_active | redir);
    push      = req_fire;
    pop       = rsp_fire & if_vld;
  end

  // FSM next state: idle until enabled, drain before going idle again.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (fetch_en) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!fetch_en && (inflight == '0)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // PC next value: a redirect always wins over the sequential increment.
  always_comb begin
    pc_d = pc_q;
    if (redir) begin
      pc_d = redir_target;
    end else if (req_fire) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  // FIFO pointers/count and kill counter; a redirect flushes the FIFO and
  // converts everything still in flight into responses to be discarded.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    kill_cnt_d = kill_cnt_q;
    if (redir) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fifo_cnt_d = '0;
      if (rsp_fire && (inflight != '0)) begin
        kill_cnt_d = CNT_W'(inflight - 1'b1);
      end else begin
        kill_cnt_d = CNT_W'(inflight);
      end
    end else begin
      if (rsp_fire && kill_active) begin
        kill_cnt_d = kill_cnt_q - 1'b1;
      end
      if (push) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
        default: fifo_cnt_d = fifo_cnt_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= ST_IDLE;
      pc_q       <= BOOT_ADDR;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      kill_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      kill_cnt_q <= kill_cnt_d;
    end
  end

  // Address FIFO storage: capture the PC of every accepted request.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else if (push && !redir) begin
      fifo_mem_q[wr_ptr_q] <= pc_q;
    end
  end

`ifdef PCGEN_PERF_EN
  logic [31:0] perf_redir_cnt_q, perf_redir_cnt_d;
  logic [31:0] perf_drop_cnt_q, perf_drop_cnt_d;

  // Saturating event counters for redirect cycles and dropped responses.
  always_comb begin
    perf_redir_cnt_d = perf_redir_cnt_q;
    perf_drop_cnt_d  = perf_drop_cnt_q;
    if (redir && (perf_redir_cnt_q != 32'hFFFF_FFFF)) begin
      perf_redir_cnt_d = perf_redir_cnt_q + 32'd1;
    end
    if (drop && (perf_drop_cnt_q != 32'hFFFF_FFFF)) begin
      perf_drop_cnt_d = perf_drop_cnt_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      perf_redir_cnt_q <= '0;
      perf_drop_cnt_q  <= '0;
    end else begin
      perf_redir_cnt_q <= perf_redir_cnt_d;
      perf_drop_cnt_q  <= perf_drop_cnt_d;
    end
  end

  assign perf_redir_cnt = perf_redir_cnt_q;
  assign perf_drop_cnt  = perf_drop_cnt_q;
`else
  // Drop indication only feeds the optional counters.
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_pc_gen_ctrl.sv
// tb_pc_gen_ctrl: directed self-checking bench for pc_gen_ctrl.
module tb_pc_gen_ctrl;

  logic        CLK;
  logic        RSTN;
  logic        fetch_en;
  logic        freeze;
  logic        trap_vld;
  logic [31:0] trap_pc;
  logic        ex_redir_vld;
  logic [31:0] ex_redir_pc;
  logic        bp_taken;
  logic [31:0] bp_pc;
  logic        req_vld;
  logic [31:0] req_addr;
  logic        req_rdy;
  logic        rsp_vld;
  logic [31:0] rsp_data;
  logic        rsp_rdy;
  logic        if_vld;
  logic [31:0] if_pc;
  logic [31:0] if_pc_nxt;
  logic [31:0] if_instr;
  logic        if_rdy;
`ifdef PCGEN_PERF_EN
  logic [31:0] perf_redir_cnt;
  logic [31:0] perf_drop_cnt;
`endif

  int checks;
  int failures;

  pc_gen_ctrl #(
    .XLEN(32),
    .MAX_OUTSTANDING(2),
    .BOOT_ADDR(32'h0000_0000)
  ) dut (
    .CLK(CLK),
    .RSTN(RSTN),
    .fetch_en(fetch_en),
    .freeze(freeze),
    .trap_vld(trap_vld),
    .trap_pc(trap_pc),
    .ex_redir_vld(ex_redir_vld),
    .ex_redir_pc(ex_redir_pc),
    .bp_taken(bp_taken),
    .bp_pc(bp_pc),
    .req_vld(req_vld),
    .req_addr(req_addr),
    .req_rdy(req_rdy),
    .rsp_vld(rsp_vld),
    .rsp_data(rsp_data),
    .rsp_rdy(rsp_rdy),
    .if_vld(if_vld),
    .if_pc(if_pc),
    .if_pc_nxt(if_pc_nxt),
    .if_instr(if_instr),
    .if_rdy(if_rdy)
`ifdef PCGEN_PERF_EN
    ,
    .perf_redir_cnt(perf_redir_cnt),
    .perf_drop_cnt(perf_drop_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs;
    fetch_en     = 1'b0;
    freeze       = 1'b0;
    trap_vld     = 1'b0;
    trap_pc      = '0;
    ex_redir_vld = 1'b0;
    ex_redir_pc  = '0;
    bp_taken     = 1'b0;
    bp_pc        = '0;
    req_rdy      = 1'b0;
    rsp_vld      = 1'b0;
    rsp_data     = '0;
    if_rdy       = 1'b0;
  endtask

  task automatic do_reset;
    clear_inputs();
    RSTN = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RSTN = 1'b1;
  endtask

  task automatic test_reset;
    clear_inputs();
    RSTN = 1'b0;
    #1;
    checks++; if (req_vld !== 1'b0) begin failures++; $display("FAIL rst_req_vld: got %b expected 0", req_vld); end
    checks++; if (if_vld !== 1'b0) begin failures++; $display("FAIL rst_if_vld: got %b expected 0", if_vld); end
    checks++; if (rsp_rdy !== 1'b0) begin failures++; $display("FAIL rst_rsp_rdy: got %b expected 0", rsp_rdy); end
    checks++; if (req_addr !== 32'h0) begin failures++; $display("FAIL rst_req_addr: got %h expected %h", req_addr, 32'h0); end
    fetch_en = 1'b1;
    req_rdy  = 1'b1;
    tick();
    checks++; if (req_vld !== 1'b0) begin failures++; $display("FAIL rst_held_req_vld: got %b expected 0", req_vld); end
    RSTN = 1'b1;
    #1;
    checks++; if (req_vld !== 1'b0) begin failures++; $display("FAIL rst_idle_req_vld: got %b expected 0", req_vld); end
    tick();
    checks++; if (req_vld !== 1'b1 || req_addr !== 32'h0) begin failures++; $display("FAIL rst_first_req: got vld=%b addr=%h expected vld=1 addr=%h", req_vld, req_addr, 32'h0); end
    tick();
    checks++; if (req_addr !== 32'h4) begin failures++; $display("FAIL rst_second_req: got %h expected %h", req_addr, 32'h4); end
    RSTN = 1'b0;
    #1;
    checks++; if (req_addr !== 32'h0 || req_vld !== 1'b0) begin failures++; $display("FAIL rst_async: got vld=%b addr=%h expected vld=0 addr=%h", req_vld, req_addr, 32'h0); end
  endtask

  task automatic test_sequential;
    do_reset();
    fetch_en = 1'b1; req_rdy = 1'b1; if_rdy = 1'b1;
    #1;
    checks++; if (req_vld !== 1'b0) begin failures++; $display("FAIL seq_idle: got %b expected 0", req_vld); end
    tick();
    checks++; if (req_vld !== 1'b1 || req_addr !== 32'h0) begin failures++; $display("FAIL seq_req0: got vld=%b addr=%h expected vld=1 addr=%h", req_vld, req_addr, 32'h0); end
    checks++; if (if_vld !== 1'b0) begin failures++; $display("FAIL seq_no_if: got %b expected 0", if_vld); end
    tick();
    rsp_vld = 1'b1; rsp_data = 32'hA000_0000;
    #1;
    checks++; if (req_addr !== 32'h4) begin failures++; $display("FAIL seq_req1: got %h expected %h", req_addr, 32'h4); end
    checks++; if (if_vld !== 1'b1 || if_pc !== 32'h0 || if_pc_nxt !== 32'h4 || if_instr !== 32'hA000_0000) begin failures++; $display("FAIL seq_if0: got vld=%b pc=%h nxt=%h instr=%h expected 1 %h %h %h", if_vld, if_pc, if_pc_nxt, if_instr, 32'h0, 32'h4, 32'hA000_0000); end
    tick();
    rsp_data = 32'hA000_0001;
    #1;
    checks++; if (req_addr !== 32'h8) begin failures++; $display("FAIL seq_req2: got %h expected %h", req_addr, 32'h8); end
    checks++; if (if_vld !== 1'b1 || if_pc !== 32'h4 || if_pc_nxt !== 32'h8) begin failures++; $display("FAIL seq_if1: got vld=%b pc=%h nxt=%h expected 1 %h %h", if_vld, if_pc, if_pc_nxt, 32'h4, 32'h8); end
    tick();
    fetch_en = 1'b0; rsp_data = 32'hA000_0002;
    #1;
    checks++; if (req_vld !== 1'b0) begin failures++; $display("FAIL seq_stop_req: got %b expected 0", req_vld); end
    checks++; if (if_vld !== 1'b1 || if_pc !== 32'h8 || if_pc_nxt !== 32'hC) begin failures++; $display("FAIL seq_if2: got vld=%b pc=%h nxt=%h expected 1 %h %h", if_vld, if_pc, if_pc_nxt, 32'h8, 32'hC); end
    tick();
    rsp_vld = 1'b0;
    #1;
    checks++; if (if_vld !== 1'b0 || req_vld !== 1'b0) begin failures++; $display("FAIL seq_drained: got if_vld=%b req_vld=%b expected 0 0", if_vld, req_vld); end
    tick();
    fetch_en = 1'b1;
    #1;
    checks++; if (req_vld !== 1'b0) begin failures++; $display("FAIL seq_back_idle: got %b expected 0", req_vld); end
    tick();
    checks++; if (req_vld !== 1'b1 || req_addr !== 32'hC) begin failures++; $display("FAIL seq_resume: got vld=%b addr=%h expected vld=1 addr=%h", req_vld, req_addr, 32'hC); end
  endtask

  task automatic test_max_outstanding;
    do_reset();
    fetch_en = 1'b1; req_rdy = 1'b1; if_rdy = 1'b1;
    tick();
    checks++; if (req_vld !== 1'b1 || req_addr !== 32'h0) begin failures++; $display("FAIL max_req0: got vld=%b addr=%h expected vld=1 addr=%h", req_vld, req_addr, 32'h0); end
    tick();
    checks++; if (req_vld !== 1'b1 || req_addr !== 32'h4) begin failures++; $display("FAIL max_req1: got vld=%b addr=%h expected vld=1 addr=%h", req_vld, req_addr, 32'h4); end
    tick();
    checks++; if (req_vld !== 1'b0) begin failures++; $display("FAIL max_cap0: got %b expected 0", req_vld); end
    tick();
    checks++; if (req_vld !== 1'b0) begin failures++; $display("FAIL max_cap1: got %b expected 0", req_vld); end
    rsp_vld = 1'b1; rsp_data = 32'hB000_0000;
    #1;
    checks++; if (req_vld !== 1'b0 || if_vld !== 1'b1 || if_pc !== 32'h0) begin failures++; $display("FAIL max_rsp: got req_vld=%b if_vld=%b if_pc=%h expected 0 1 %h", req_vld, if_vld, if_pc, 32'h0); end
    tick();
    rsp_vld = 1'b0;
    #1;
    checks++; if (req_vld !== 1'b1 || req_addr !== 32'h8) begin failures++; $display("FAIL max_reopen: got vld=%b addr=%h expected vld=1 addr=%h", req_vld, req_addr, 32'h8); end
  endtask

  task automatic test_redirect;
    do_reset();
    fetch_en = 1'b1; req_rdy = 1'b1; if_rdy = 1'b1;
    tick();
    tick();
    tick();
    ex_redir_vld = 1'b1; ex_redir_pc = 32'h100;
    #1;
    checks++; if (req_vld !== 1'b0 || rsp_rdy !== 1'b1) begin failures++; $display("FAIL redir_cycle: got req_vld=%b rsp_rdy=%b expected 0 1", req_vld, rsp_rdy); end
    tick();
    ex_redir_vld = 1'b0;
    rsp_vld = 1'b1; rsp_data = 32'hDEAD_0000;
    #1;
    checks++; if (if_vld !== 1'b0 || rsp_rdy !== 1'b1) begin failures++; $display("FAIL redir_drop0: got if_vld=%b rsp_rdy=%b expected 0 1", if_vld, rsp_rdy); end
    checks++; if (req_vld !== 1'b0 || req_addr !== 32'h100) begin failures++; $display("FAIL redir_wait: got vld=%b addr=%h expected vld=0 addr=%h", req_vld, req_addr, 32'h100); end
    tick();
    rsp_data = 32'hDEAD_0004;
    #1;
    checks++; if (if_vld !== 1'b0) begin failures++; $display("FAIL redir_drop1: got %b expected 0", if_vld); end
    checks++; if (req_vld !== 1'b1 || req_addr !== 32'h100) begin failures++; $display("FAIL redir_req: got vld=%b addr=%h expected vld=1 addr=%h", req_vld, req_addr, 32'h100); end
    tick();
    rsp_data = 32'h1234_5678; req_rdy = 1'b0;
    #1;
    checks++; if (if_vld !== 1'b1 || if_pc !== 32'h100 || if_pc_nxt !== 32'h104 || if_instr !== 32'h1234_5678) begin failures++; $display("FAIL redir_deliver: got vld=%b pc=%h nxt=%h instr=%h expected 1 %h %h %h", if_vld, if_pc, if_pc_nxt, if_instr, 32'h100, 32'h104, 32'h1234_5678); end
    tick();
    rsp_vld = 1'b0;
`ifdef PCGEN_PERF_EN
    checks++; if (perf_drop_cnt !== 32'd2) begin failures++; $display("FAIL perf_drop: got %0d expected 2", perf_drop_cnt); end
    checks++; if (perf_redir_cnt !== 32'd1) begin failures++; $display("FAIL perf_redir: got %0d expected 1", perf_redir_cnt); end
`endif
  endtask

  task automatic test_priority;
    do_reset();
    fetch_en = 1'b1;
    tick();
    trap_vld = 1'b1; trap_pc = 32'h80; bp_taken = 1'b1; bp_pc = 32'h200;
    #1;
    checks++; if (req_vld !== 1'b0) begin failures++; $display("FAIL prio_redir_blocks: got %b expected 0", req_vld); end
    tick();
    trap_vld = 1'b0; bp_taken = 1'b0;
    #1;
    checks++; if (req_vld !== 1'b1 || req_addr !== 32'h80) begin failures++; $display("FAIL prio_trap_bp: got vld=%b addr=%h expected vld=1 addr=%h", req_vld, req_addr, 32'h80); end
    bp_taken = 1'b1; bp_pc = 32'h203;
    tick();
    bp_taken = 1'b0;
    #1;
    checks++; if (req_addr !== 32'h200) begin failures++; $display("FAIL prio_bp_align: got %h expected %h", req_addr, 32'h200); end
    ex_redir_vld = 1'b1; ex_redir_pc = 32'h300; bp_taken = 1'b1; bp_pc = 32'h400;
    tick();
    ex_redir_vld = 1'b0; bp_taken = 1'b0;
    #1;
    checks++; if (req_addr !== 32'h300) begin failures++; $display("FAIL prio_ex_bp: got %h expected %h", req_addr, 32'h300); end
    trap_vld = 1'b1; trap_pc = 32'h40; ex_redir_vld = 1'b1; ex_redir_pc = 32'h500;
    tick();
    trap_vld = 1'b0; ex_redir_vld = 1'b0;
    #1;
    checks++; if (req_addr !== 32'h40) begin failures++; $display("FAIL prio_trap_ex: got %h expected %h", req_addr, 32'h40); end
  endtask

  task automatic test_wrap;
    do_reset();
    fetch_en = 1'b1; req_rdy = 1'b1; if_rdy = 1'b1;
    trap_vld = 1'b1; trap_pc = 32'hFFFF_FFFC;
    tick();
    trap_vld = 1'b0;
    #1;
    checks++; if (req_vld !== 1'b1 || req_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_top: got vld=%b addr=%h expected vld=1 addr=%h", req_vld, req_addr, 32'hFFFF_FFFC); end
    tick();
    rsp_vld = 1'b1; rsp_data = 32'hC0DE_0001;
    #1;
    checks++; if (req_addr !== 32'h0) begin failures++; $display("FAIL wrap_next: got %h expected %h", req_addr, 32'h0); end
    checks++; if (if_pc !== 32'hFFFF_FFFC || if_pc_nxt !== 32'h0) begin failures++; $display("FAIL wrap_if: got pc=%h nxt=%h expected %h %h", if_pc, if_pc_nxt, 32'hFFFF_FFFC, 32'h0); end
    tick();
    rsp_vld = 1'b0;
  endtask

  task automatic test_back_to_back;
    do_reset();
    fetch_en = 1'b1; req_rdy = 1'b1; if_rdy = 1'b0;
    tick();
    tick();
    req_rdy = 1'b0;
    rsp_vld = 1'b1; rsp_data = 32'h1111_2222;
    #1;
    checks++; if (rsp_rdy !== 1'b0 || if_vld !== 1'b1 || if_pc !== 32'h0) begin failures++; $display("FAIL bp_stall0: got rsp_rdy=%b if_vld=%b if_pc=%h expected 0 1 %h", rsp_rdy, if_vld, if_pc, 32'h0); end
    checks++; if (req_vld !== 1'b1 || req_addr !== 32'h4) begin failures++; $display("FAIL bp_req_hold0: got vld=%b addr=%h expected vld=1 addr=%h", req_vld, req_addr, 32'h4); end
    tick();
    checks++; if (rsp_rdy !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h1111_2222) begin failures++; $display("FAIL bp_stall1: got rsp_rdy=%b if_pc=%h instr=%h expected 0 %h %h", rsp_rdy, if_pc, if_instr, 32'h0, 32'h1111_2222); end
    checks++; if (req_vld !== 1'b1 || req_addr !== 32'h4) begin failures++; $display("FAIL bp_req_hold1: got vld=%b addr=%h expected vld=1 addr=%h", req_vld, req_addr, 32'h4); end
    if_rdy = 1'b1;
    #1;
    checks++; if (rsp_rdy !== 1'b1 || if_vld !== 1'b1 || if_pc !== 32'h0) begin failures++; $display("FAIL bp_release: got rsp_rdy=%b if_vld=%b if_pc=%h expected 1 1 %h", rsp_rdy, if_vld, if_pc, 32'h0); end
    tick();
    rsp_vld = 1'b0;
    #1;
    checks++; if (if_vld !== 1'b0) begin failures++; $display("FAIL bp_popped: got %b expected 0", if_vld); end
    freeze = 1'b1; req_rdy = 1'b1;
    #1;
    checks++; if (req_vld !== 1'b0) begin failures++; $display("FAIL bp_freeze: got %b expected 0", req_vld); end
  endtask

  task automatic test_protocol_error;
    do_reset();
    if_rdy = 1'b1;
    rsp_vld = 1'b1; rsp_data = 32'hBAD0_0000;
    #1;
    checks++; if (rsp_rdy !== 1'b1 || if_vld !== 1'b0) begin failures++; $display("FAIL perr_ignore: got rsp_rdy=%b if_vld=%b expected 1 0", rsp_rdy, if_vld); end
    tick();
    rsp_vld = 1'b0; fetch_en = 1'b1; req_rdy = 1'b1;
    tick();
    checks++; if (req_vld !== 1'b1 || req_addr !== 32'h0) begin failures++; $display("FAIL perr_recover: got vld=%b addr=%h expected vld=1 addr=%h", req_vld, req_addr, 32'h0); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clear_inputs();
    RSTN = 1'b0;
    test_reset();
    test_sequential();
    test_max_outstanding();
    test_redirect();
    test_priority();
    test_wrap();
    test_back_to_back();
    test_protocol_error();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_gen_ctrl.md
Name: pc_gen_ctrl

Overview:
- Next-generation fetch PC generator: parametrised address width, multiple outstanding fetch requests, prioritised redirects.
- Issues sequential fetch requests to instruction memory and tracks each in-flight request address in a small FIFO.
- Pairs each returned instruction with its PC for the IF stage.
- Squashes stale responses after any redirect (trap, execute-stage jump/branch, branch predictor).

Parameters:
- XLEN, 32, address/PC width in bits.
- MAX_OUTSTANDING, 2, maximum in-flight fetch requests (power of two, ≥1).
- BOOT_ADDR, 32'h0000_0000, PC loaded on reset.

Ports:
- CLK  input  1  clock.
- RSTN  input  1  reset, asynchronous, active-low.
- fetch_en  input  1  start/continue fetching.
- freeze  input  1  suppress new requests; in-flight responses still handled.
- trap_vld  input  1  trap redirect, highest priority.
- trap_pc  input  XLEN  trap target.
- ex_redir_vld  input  1  EX jump/mispredict redirect.
- ex_redir_pc  input  XLEN  EX target.
- bp_taken  input  1  predictor redirect, lowest priority.
- bp_pc  input  XLEN  predicted target.
- req_vld  output  1  fetch request valid.
- req_addr  output  XLEN  fetch address.
- req_rdy  input  1  memory accepts request.
- rsp_vld  input  1  memory returns instruction (in order).
- rsp_data  input  32  instruction word.
- rsp_rdy  output  1  response accepted.
- if_vld  output  1  instruction valid to IF.
- if_pc  output  XLEN  PC of delivered instruction.
- if_pc_nxt  output  XLEN  if_pc + 4.
- if_instr  output  32  delivered instruction.
- if_rdy  input  1  IF stage accepts.

Behaviour:
- FSM states:
  - IDLE: reset state. Goes to RUN when fetch_en=1.
  - RUN: goes back to IDLE when fetch_en=0 and inflight=0. While fetch_en=0 in RUN, no new requests issue.
- Reset values:
  - pc=BOOT_ADDR, req_vld=0, if_vld=0, rsp_rdy=0.
  - FIFO empty, kill_cnt=0, state=IDLE.
- Definitions:
  - inflight = fifo_cnt + kill_cnt.
  - req_fire = req_vld & req_rdy.
  - rsp_fire = rsp_vld & rsp_rdy.
  - redir = trap_vld | ex_redir_vld | bp_taken.
- req_vld = state==RUN & fetch_en & ~freeze & ~redir & inflight<MAX_OUTSTANDING.
- req_addr = pc. req_vld/req_addr hold stable until req_rdy.
- On req_fire:
  - Push pc into the address FIFO.
  - pc <= pc+4, modulo 2^XLEN (0xFFFF_FFFC wraps to 0).
- Redirect:
  - Target selected by priority trap > ex > bp. Target low two bits are forced to 0.
  - pc <= target. First request to the target can appear at cycle N+1.
  - All in-flight requests become stale: kill_cnt <= inflight − rsp_fire; FIFO flushed.
- Response handling:
  - rsp_rdy = kill_cnt!=0 | redir | if_rdy.
  - Response with kill_cnt!=0 is dropped: kill_cnt−1, if_vld=0.
  - Response in a redirect cycle is dropped and counted inside the kill formula.
- Delivery:
  - if_vld = rsp_vld & kill_cnt==0 & ~redir.
  - if_pc = FIFO head; if_instr = rsp_data.
  - On rsp_fire with if_vld, the FIFO head is popped.
- Simultaneous events:
  - Push and pop in the same cycle leave fifo_cnt unchanged.
  - Redirect overrides any pending increment of pc.
- freeze never drops responses; backpressure to memory is via rsp_rdy.
- Response arriving with FIFO empty and kill_cnt=0 is a protocol error; the block ignores it (rsp_rdy stays 1, no if_vld).
- Asynchronous reset mid-operation clears all state immediately; responses to pre-reset requests are not tracked.

Optional Feature:
- Macro: PCGEN_PERF_EN.
- When defined, the block adds:
  - Output perf_redir_cnt [31:0]: counts redirect cycles.
  - Output perf_drop_cnt [31:0]: counts dropped responses.
  - Both reset to 0 and saturate at 0xFFFF_FFFF.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, fetch_en=1, req_rdy=1, rsp returns 1 cycle later → req_addr 0x0,0x4,0x8; if_pc 0x0,0x4,0x8 with if_pc_nxt 0x4,0x8,0xC.
- MAX_OUTSTANDING=2, no responses → exactly two requests (0x0,0x4), then req_vld=0 until a response fires.
- Two in flight, ex_redir_vld with ex_redir_pc=0x100 → next req_addr=0x100; the two old responses are dropped (if_vld=0); the response for 0x100 delivers if_pc=0x100.
- trap_vld (0x80) and bp_taken (0x200) in the same cycle → req_addr=0x80; bp_pc=0x203 alone → req_addr=0x200.
- pc=0xFFFF_FFFC, XLEN=32 → following request is req_addr=0x0.
- if_rdy=0 while rsp_vld=1 → rsp_rdy=0; FIFO head, if_pc and if_instr are held until if_rdy=1. With PCGEN_PERF_EN, the redirect scenario ends with perf_drop_cnt=2 and perf_redir_cnt=1.
